// File: rtl/as2650_wb_pkg.sv
// Shared definitions for the AS2650 Wishbone loader: register map,
// CTRL/STATUS bit positions and FSM state encoding.
package as2650_wb_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_ADDR = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_AUTOINC = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_ERR     = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/as2650_wb_loader.sv
// Wishbone slave that holds the AS2650 in reset and gives firmware byte access
// to its memory port. Define AS2650_WB_TIMEOUT_EN to bound the mem_ack wait.
module as2650_wb_loader
  import as2650_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          MEM_AW         = 15,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              cpu_rst_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output state_t            dbg_state
);

  // Handshakes: a bus request is accepted only in IDLE when stb&cyc hit our
  // window; wbs_ack_o answers it with a one-cycle pulse. On the memory side
  // mem_req is a level held with stable mem_* until mem_ack is sampled high.
  state_t            state;
  logic              run;
  logic              autoinc;
  logic              err;
  logic [MEM_AW-1:0] addr_q;
  logic              sel_hit;
  logic [1:0]        reg_idx;
  logic [31:0]       rd_val;
  logic [15:0]       addr_cur16;
  logic [15:0]       addr_new16;
  logic              unused_ok;

`ifdef AS2650_WB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
`endif

  assign sel_hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx   = wbs_adr_i[3:2];
  assign cpu_rst_o = ~run;
  assign dbg_state = state;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16], 8'(TIMEOUT_CYCLES)};

  // Byte-lane merge of the pointer; bits above MEM_AW fall away on truncation.
  assign addr_cur16 = 16'(addr_q);
  assign addr_new16 = {wbs_sel_i[1] ? wbs_dat_i[15:8] : addr_cur16[15:8],
                       wbs_sel_i[0] ? wbs_dat_i[7:0]  : addr_cur16[7:0]};

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_val[CTRL_RUN]     = run;
        rd_val[CTRL_AUTOINC] = autoinc;
      end
      REG_ADDR: rd_val = 32'(addr_q);
      REG_STAT: begin
        rd_val[STAT_BUSY] = (state != ST_IDLE);
        rd_val[STAT_ERR]  = err;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      run       <= 1'b0;
      autoinc   <= 1'b1;
      err       <= 1'b0;
      addr_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef AS2650_WB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_hit) begin
            state     <= ST_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? 32'h0 : rd_val;
            case (reg_idx)
              REG_CTRL: begin
                if (wbs_we_i && wbs_sel_i[0]) begin
                  run     <= wbs_dat_i[CTRL_RUN];
                  autoinc <= wbs_dat_i[CTRL_AUTOINC];
                end
              end
              REG_ADDR: begin
                if (wbs_we_i) addr_q <= addr_new16[MEM_AW-1:0];
              end
              REG_STAT: begin
                if (wbs_we_i && wbs_sel_i[0] && wbs_dat_i[STAT_ERR]) err <= 1'b0;
              end
              default: begin
                // DATA: the memory port belongs to the CPU while it runs.
                if (run) begin
                  err <= 1'b1;
                end else if (!wbs_we_i || wbs_sel_i[0]) begin
                  state     <= ST_MEM;
                  wbs_ack_o <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= wbs_we_i;
                  mem_addr  <= addr_q;
                  if (wbs_we_i) mem_wdata <= wbs_dat_i[7:0];
`ifdef AS2650_WB_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
                end
              end
            endcase
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            state     <= ST_ACK;
            wbs_ack_o <= 1'b1;
            if (!mem_we) wbs_dat_o <= {24'h0, mem_rdata};
            if (autoinc) addr_q <= addr_q + MEM_AW'(1);
          end
`ifdef AS2650_WB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            state     <= ST_ACK;
            wbs_ack_o <= 1'b1;
            if (!mem_we) wbs_dat_o <= 32'hFFFF_FFFF;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_as2650_wb_loader.sv
// Directed bench for as2650_wb_loader: Wishbone driver tasks, a memory
// responder feeding an op scoreboard, and hand-computed expected values.
module tb_as2650_wb_loader;
  import as2650_wb_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] dat_o;
  logic        cpu_rst;
  logic        mem_req, mem_we, mem_ack;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [23:0] op;
  int          ack_delay  = 3;
  logic        mem_ack_en = 1'b1;
  logic [7:0]  mem_resp   = 8'h00;
  int          mem_glitch = 0;

  logic [31:0] rd;
  int          lat;
  logic        acked;
  logic        got_ack;

  as2650_wb_loader dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .cpu_rst_o(cpu_rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // memory responder: logs each op, acks ack_delay cycles after mem_req rises
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ack_en) begin
        op = {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
        obs_q.push_back(op);
        for (int i = 1; i < ack_delay; i++) begin
          @(negedge clk);
          if (!mem_req || {mem_we, mem_addr} != op[23:8]) mem_glitch++;
        end
        mem_rdata = mem_resp;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        if (mem_req) mem_glitch++;
      end
    end
  end

  task automatic sb_check(input string tag);
    check({tag, "_opcount"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_op"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    check({tag, "_memstable"}, mem_glitch, 0);
  endtask

  // driver tasks
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int limit,
                         output logic [31:0] r, output int l, output logic k);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; wdat = d;
    l = 0; k = 1'b0; r = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      l++;
      if (ack) begin
        k = 1'b1;
        r = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (k) begin
      @(negedge clk);
      check("ack_pulse", ack, 1'b0);
    end
  endtask

  task automatic reg_wr(input logic [1:0] idx, input logic [3:0] s, input logic [31:0] d, input string tag);
    wb_xfer(1'b1, BASE | {28'h0, idx, 2'b00}, s, d, 8, rd, lat, acked);
    check({tag, "_ack"}, acked, 1'b1);
    check({tag, "_lat"}, lat, 1);
  endtask

  task automatic reg_rd(input logic [1:0] idx, input logic [31:0] exp, input string tag);
    wb_xfer(1'b0, BASE | {28'h0, idx, 2'b00}, 4'hF, 32'h0, 8, rd, lat, acked);
    check({tag, "_ack"}, acked, 1'b1);
    check({tag, "_lat"}, lat, 1);
    check(tag, rd, exp);
  endtask

  task automatic data_rd(input logic [31:0] exp, input string tag);
    wb_xfer(1'b0, BASE | 32'h8, 4'hF, 32'h0, 40, rd, lat, acked);
    check({tag, "_ack"}, acked, 1'b1);
    check(tag, rd, exp);
  endtask

  task automatic data_wr(input logic [7:0] d, input logic [3:0] s, input string tag);
    wb_xfer(1'b1, BASE | 32'h8, s, {24'h0, d}, 40, rd, lat, acked);
    check({tag, "_ack"}, acked, 1'b1);
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_dat_o", dat_o, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    reg_rd(REG_CTRL, 32'h2, "rst_ctrl");
    reg_rd(REG_ADDR, 32'h0, "rst_addr");
    reg_rd(REG_STAT, 32'h0, "rst_stat");

    // writes with auto-increment across the top of memory
    ack_delay = 3;
    reg_wr(REG_ADDR, 4'h3, 32'h7FFE, "wr_addr_7ffe");
    data_wr(8'hA5, 4'h1, "wr_a5");
    data_wr(8'h5A, 4'h1, "wr_5a");
    exp_q.push_back({1'b1, 15'h7FFE, 8'hA5});
    exp_q.push_back({1'b1, 15'h7FFF, 8'h5A});
    sb_check("wrap");
    reg_rd(REG_ADDR, 32'h0, "wrap_addr");

    // read with data from memory
    reg_wr(REG_ADDR, 4'h3, 32'h0100, "wr_addr_100");
    mem_resp = 8'h3C;
    data_rd(32'h0000_003C, "rd_3c");
    check("rd_req_dropped", mem_req, 1'b0);
    exp_q.push_back({1'b0, 15'h0100, 8'h00});
    sb_check("rd");
    reg_rd(REG_ADDR, 32'h0101, "rd_addr_inc");

    // DATA write without lane 0: plain ack, no op
    data_wr(8'h99, 4'h2, "wr_nolane");
    check("wr_nolane_lat", lat, 1);
    sb_check("nolane");
    reg_rd(REG_ADDR, 32'h0101, "nolane_addr");

    // CPU running: DATA access refused and flagged
    reg_wr(REG_CTRL, 4'h1, 32'h1, "wr_ctrl_run");
    check("run_cpu_rst", cpu_rst, 1'b0);
    reg_rd(REG_CTRL, 32'h1, "run_ctrl");
    data_wr(8'h77, 4'h1, "run_wr");
    check("run_wr_lat", lat, 1);
    reg_rd(REG_STAT, 32'h2, "run_stat_err");
    data_rd(32'h0, "run_rd");
    check("run_rd_lat", lat, 1);
    sb_check("run");
    reg_wr(REG_STAT, 4'h1, 32'h2, "clr_err");
    reg_rd(REG_STAT, 32'h0, "stat_cleared");

    // no auto-increment; pointer bit 15 ignored
    reg_wr(REG_CTRL, 4'h1, 32'h0, "wr_ctrl_0");
    check("hold_cpu_rst", cpu_rst, 1'b1);
    reg_wr(REG_ADDR, 4'h3, 32'h8042, "wr_addr_8042");
    reg_rd(REG_ADDR, 32'h0042, "addr_bit15");
    ack_delay = 1;
    mem_resp  = 8'h11;
    data_rd(32'h11, "noinc_rd1");
    mem_resp  = 8'h22;
    data_rd(32'h22, "noinc_rd2");
    exp_q.push_back({1'b0, 15'h0042, 8'h00});
    exp_q.push_back({1'b0, 15'h0042, 8'h00});
    sb_check("noinc");
    reg_rd(REG_ADDR, 32'h0042, "noinc_addr");

    // unselected addresses get no ack
    wb_xfer(1'b0, BASE | 32'h10, 4'hF, 32'h0, 8, rd, lat, acked);
    check("unsel_above", acked, 1'b0);
    wb_xfer(1'b1, 32'h2000_0004, 4'hF, 32'h1, 8, rd, lat, acked);
    check("unsel_other", acked, 1'b0);
    reg_rd(REG_CTRL, 32'h0, "unsel_ctrl_kept");

    // reset in the middle of a memory op
    mem_ack_en = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h8; sel = 4'hF;
    @(negedge clk);
    check("rstmem_req_up", mem_req, 1'b1);
    check("rstmem_state", dbg_state, ST_MEM);
    rst = 1'b1; stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    check("rstmem_req_drop", mem_req, 1'b0);
    check("rstmem_ack", ack, 1'b0);
    check("rstmem_cpu_rst", cpu_rst, 1'b1);
    rst = 1'b0;
    got_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack) got_ack = 1'b1;
    end
    check("rstmem_noack", got_ack, 1'b0);
    reg_rd(REG_CTRL, 32'h2, "rstmem_ctrl");
    reg_rd(REG_ADDR, 32'h0, "rstmem_addr");

`ifdef AS2650_WB_TIMEOUT_EN
    // memory never answers: bounded wait, error data, pointer untouched
    reg_wr(REG_ADDR, 4'h3, 32'h0042, "to_addr");
    wb_xfer(1'b0, BASE | 32'h8, 4'hF, 32'h0, 400, rd, lat, acked);
    check("to_ack", acked, 1'b1);
    check("to_lat_min", lat >= 256, 1'b1);
    check("to_data", rd, 32'hFFFF_FFFF);
    check("to_req_drop", mem_req, 1'b0);
    reg_rd(REG_STAT, 32'h2, "to_stat");
    reg_rd(REG_ADDR, 32'h0042, "to_addr_kept");
`endif

    mem_ack_en = 1'b1;
    sb_check("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
